sgdh_traffic_light_monitor: RTL and testbench

Receive-side checker for the 3-bit one-hot `light` bus driven by `sgdh_traffic_light_core`. It decodes the bus into a phase and measures each phase's lit duration. It checks encoding, RED→GREEN→YELLOW order and per-phase duration against the same timing parameters as the core, and reports violations as pulses plus sticky flags. It sits beside the core, in the FPGA top or the testbench, as a run-time protocol monitor.

---
 rtl/sgdh_traffic_light_monitor_pkg.sv | 49 ++++
 rtl/sgdh_tl_light_decoder.sv | 35 +++
 rtl/sgdh_traffic_light_monitor.sv | 135 +++++++++++++
 tb/tb_sgdh_traffic_light_monitor.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgdh_traffic_light_monitor_pkg.sv
// Shared types, light codes and lookup helpers for the traffic-light monitor.
// Optional statistics counter is enabled by defining SGDH_TL_MON_STATS_EN.
package sgdh_traffic_light_monitor_pkg;

  localparam int TIMER_BIT_WIDTH = 4;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_DARK   = 3'b000;

  typedef enum logic [1:0] {
    S_RED     = 2'b00,
    S_GREEN   = 2'b01,
    S_YELLOW  = 2'b10,
    S_UNKNOWN = 2'b11
  } phase_t;

  // Legal cycle is RED -> GREEN -> YELLOW -> RED; UNKNOWN has no successor.
  function automatic phase_t successor(input phase_t p);
    case (p)
      S_RED:    return S_GREEN;
      S_GREEN:  return S_YELLOW;
      S_YELLOW: return S_RED;
      default:  return S_UNKNOWN;
    endcase
  endfunction

  function automatic logic [TIMER_BIT_WIDTH-1:0] expected_time(
    input phase_t p,
    input int     red_t,
    input int     green_t,
    input int     yellow_t
  );
    case (p)
      S_RED:    return TIMER_BIT_WIDTH'(red_t);
      S_GREEN:  return TIMER_BIT_WIDTH'(green_t);
      S_YELLOW: return TIMER_BIT_WIDTH'(yellow_t);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [TIMER_BIT_WIDTH-1:0] sat_increment(
    input logic [TIMER_BIT_WIDTH-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sgdh_tl_light_decoder.sv
// Combinational classifier for the one-hot light bus: valid code, dark, or illegal.
module sgdh_tl_light_decoder
  import sgdh_traffic_light_monitor_pkg::*;
(
  input  logic [2:0] light,
  output logic       valid,
  output logic       dark,
  output logic       illegal,
  output phase_t     phase
);

  always_comb begin
    valid   = 1'b0;
    dark    = 1'b0;
    illegal = 1'b0;
    phase   = S_UNKNOWN;
    case (light)
      LIGHT_RED: begin
        valid = 1'b1;
        phase = S_RED;
      end
      LIGHT_GREEN: begin
        valid = 1'b1;
        phase = S_GREEN;
      end
      LIGHT_YELLOW: begin
        valid = 1'b1;
        phase = S_YELLOW;
      end
      LIGHT_DARK: dark = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/sgdh_traffic_light_monitor.sv
// Run-time protocol monitor for the traffic-light core's light bus.
// Define SGDH_TL_MON_STATS_EN to build the completed-cycle counter.
module sgdh_traffic_light_monitor
  import sgdh_traffic_light_monitor_pkg::*;
#(
  parameter int RED_TIME    = 5,
  parameter int YELLOW_TIME = 2,
  parameter int GREEN_TIME  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic [2:0]                 light,
  input  logic                       err_clr,
  output logic [1:0]                 phase,
  output logic [TIMER_BIT_WIDTH-1:0] phase_len,
  output logic                       err_code,
  output logic                       err_order,
  output logic                       err_dur,
  output logic [2:0]                 err_sticky,
  output logic [CNT_W-1:0]           cycle_cnt
);

  localparam int TIME_LIMIT = 1 << TIMER_BIT_WIDTH;

  if (RED_TIME <= 0 || RED_TIME >= TIME_LIMIT ||
      YELLOW_TIME <= 0 || YELLOW_TIME >= TIME_LIMIT ||
      GREEN_TIME <= 0 || GREEN_TIME >= TIME_LIMIT) begin : g_bad_time
    $error("sgdh_traffic_light_monitor: *_TIME must be in 1..2^TIMER_BIT_WIDTH-1");
  end

  logic   dec_valid;
  logic   dec_dark;
  logic   dec_illegal;
  phase_t dec_phase;

  sgdh_tl_light_decoder u_decoder (
    .light   (light),
    .valid   (dec_valid),
    .dark    (dec_dark),
    .illegal (dec_illegal),
    .phase   (dec_phase)
  );

  phase_t                     phase_reg,    phase_next;
  logic [TIMER_BIT_WIDTH-1:0] len_reg,      len_next;
  logic                       verified_reg, verified_next;
  logic                       err_code_reg, err_code_next;
  logic                       err_order_reg, err_order_next;
  logic                       err_dur_reg,  err_dur_next;
  logic [2:0]                 sticky_reg,   sticky_next;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      phase_reg     <= S_UNKNOWN;
      len_reg       <= '0;
      verified_reg  <= 1'b0;
      err_code_reg  <= 1'b0;
      err_order_reg <= 1'b0;
      err_dur_reg   <= 1'b0;
      sticky_reg    <= '0;
    end else begin
      phase_reg     <= phase_next;
      len_reg       <= len_next;
      verified_reg  <= verified_next;
      err_code_reg  <= err_code_next;
      err_order_reg <= err_order_next;
      err_dur_reg   <= err_dur_next;
      sticky_reg    <= sticky_next;
    end
  end

  always_comb begin
    phase_next     = phase_reg;
    len_next       = len_reg;
    verified_next  = verified_reg;
    err_code_next  = 1'b0;
    err_order_next = 1'b0;
    err_dur_next   = 1'b0;

    if (dec_valid) begin
      if (dec_phase == phase_reg) begin
        len_next = sat_increment(len_reg);
      end else begin
        // Leaving UNKNOWN carries no order information and starts a partial phase.
        if (phase_reg != S_UNKNOWN && dec_phase != successor(phase_reg)) begin
          err_order_next = 1'b1;
        end
        if (verified_reg &&
            len_reg != expected_time(phase_reg, RED_TIME, GREEN_TIME, YELLOW_TIME)) begin
          err_dur_next = 1'b1;
        end
        phase_next    = dec_phase;
        len_next      = {{(TIMER_BIT_WIDTH-1){1'b0}}, 1'b1};
        verified_next = (phase_reg != S_UNKNOWN);
      end
    end else if (dec_dark) begin
      verified_next = 1'b0;
    end else if (dec_illegal) begin
      err_code_next = 1'b1;
      verified_next = 1'b0;
    end

    // A new error outranks a simultaneous clear.
    sticky_next = (sticky_reg & ~{3{err_clr}}) |
                  {err_dur_next, err_order_next, err_code_next};
  end

`ifdef SGDH_TL_MON_STATS_EN
  logic             cycle_evt;
  logic [CNT_W-1:0] cnt_reg;

  assign cycle_evt = dec_valid && (phase_reg == S_YELLOW) && (dec_phase == S_RED);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_reg <= '0;
    end else if (cycle_evt) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cycle_cnt = cnt_reg;
`else
  assign cycle_cnt = '0;
`endif

  assign phase      = phase_reg;
  assign phase_len  = len_reg;
  assign err_code   = err_code_reg;
  assign err_order  = err_order_reg;
  assign err_dur    = err_dur_reg;
  assign err_sticky = sticky_reg;

endmodule

// File: tb/tb_sgdh_traffic_light_monitor.sv
// Self-checking bench for sgdh_traffic_light_monitor: reference model feeds a
// scoreboard queue, plus scenario-specific checks against fixed values.
module tb_sgdh_traffic_light_monitor;

`ifdef SGDH_TL_MON_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int RT = 5;
  localparam int YT = 2;
  localparam int GT = 4;

  localparam logic [3:0] R  = 4'b0100;
  localparam logic [3:0] G  = 4'b0001;
  localparam logic [3:0] Y  = 4'b0010;
  localparam logic [3:0] D  = 4'b0000;
  localparam logic [3:0] RC = 4'b1100;
  localparam logic [3:0] GC = 4'b1001;
  localparam logic [3:0] YC = 4'b1010;

  localparam logic [19:0] RST_VEC = {2'b11, 18'd0};

  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic [2:0] light = 3'b000;
  logic       err_clr = 1'b0;
  logic [1:0] phase;
  logic [3:0] phase_len;
  logic       err_code, err_order, err_dur;
  logic [2:0] err_sticky;
  logic [7:0] cycle_cnt;
  logic [19:0] obs;

  int checks = 0;
  int errors = 0;

  logic [19:0] sb[$];

  // reference model state
  int         m_phase = 3;
  logic [3:0] m_len = 4'd0;
  bit         m_ver = 1'b0;
  logic [2:0] m_sticky = 3'b000;
  logic [7:0] m_cnt = 8'd0;

  sgdh_traffic_light_monitor dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .light      (light),
    .err_clr    (err_clr),
    .phase      (phase),
    .phase_len  (phase_len),
    .err_code   (err_code),
    .err_order  (err_order),
    .err_dur    (err_dur),
    .err_sticky (err_sticky),
    .cycle_cnt  (cycle_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {phase, phase_len, err_code, err_order, err_dur, err_sticky, cycle_cnt};

  task automatic model_reset();
    m_phase = 3;
    m_len = 4'd0;
    m_ver = 1'b0;
    m_sticky = 3'b000;
    m_cnt = 8'd0;
    sb.delete();
  endtask

  // Drive one sample and push the expected post-edge outputs.
  task automatic drive(input logic [3:0] ent);
    int p;
    int succ;
    int exp_t;
    bit ec, eo, ed;
    ec = 0; eo = 0; ed = 0;
    light = ent[2:0];
    err_clr = ent[3];
    case (ent[2:0])
      3'b100:  p = 0;
      3'b001:  p = 1;
      3'b010:  p = 2;
      3'b000:  p = -1;
      default: p = -2;
    endcase
    if (p == -1) begin
      m_ver = 0;
    end else if (p == -2) begin
      ec = 1;
      m_ver = 0;
    end else if (p == m_phase) begin
      if (m_len != 4'hF) m_len = m_len + 4'd1;
    end else begin
      if (m_phase != 3) begin
        succ = (m_phase == 0) ? 1 : (m_phase == 1) ? 2 : 0;
        eo = (p != succ);
      end
      if (m_ver) begin
        exp_t = (m_phase == 0) ? RT : (m_phase == 1) ? GT : YT;
        ed = (int'(m_len) != exp_t);
      end
      if (STATS && m_phase == 2 && p == 0) m_cnt = m_cnt + 8'd1;
      m_ver = (m_phase != 3);
      m_phase = p;
      m_len = 4'd1;
    end
    m_sticky = (m_sticky & ~{3{ent[3]}}) | {ed, eo, ec};
    sb.push_back({m_phase[1:0], m_len, ec, eo, ed, m_sticky, m_cnt});
  endtask

  task automatic test_reset();
    areset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL reset: got %h expected %h", obs, RST_VEC);
    end
    model_reset();
    areset_n = 1'b1;
  endtask

  task automatic test_nominal();
    logic [3:0] seq [13];
    logic [19:0] e;
    seq = '{R, G, G, G, G, Y, Y, R, R, R, R, R, G};
    for (int i = 0; i < 13; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL nominal[%0d]: got %h expected %h", i, obs, e);
      end
      if (i == 7) begin
        checks++;
        if (cycle_cnt !== (STATS ? 8'd1 : 8'd0)) begin
          errors++;
          $display("FAIL nominal_cycle_cnt: got %0d expected %0d", cycle_cnt, STATS ? 1 : 0);
        end
      end
      if (i == 11) begin
        checks++;
        if (phase_len !== 4'd5) begin
          errors++;
          $display("FAIL nominal_red_len: got %0d expected 5", phase_len);
        end
      end
      if (i == 12) begin
        checks++;
        if (err_sticky !== 3'b000) begin
          errors++;
          $display("FAIL nominal_sticky: got %b expected 000", err_sticky);
        end
      end
    end
  endtask

  task automatic test_dur();
    logic [3:0] seq [4];
    logic [19:0] e;
    seq = '{G, G, Y, YC};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL dur[%0d]: got %h expected %h", i, obs, e);
      end
      if (i == 2) begin
        checks++;
        if (err_dur !== 1'b1 || err_sticky !== 3'b100) begin
          errors++;
          $display("FAIL dur_pulse: got dur=%b sticky=%b expected dur=1 sticky=100", err_dur, err_sticky);
        end
      end
      if (i == 3) begin
        checks++;
        if (err_dur !== 1'b0 || err_sticky !== 3'b000) begin
          errors++;
          $display("FAIL dur_clear: got dur=%b sticky=%b expected dur=0 sticky=000", err_dur, err_sticky);
        end
      end
    end
  endtask

  task automatic test_order();
    logic [3:0] seq [6];
    logic [19:0] e;
    seq = '{R, R, R, R, R, Y};
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL order[%0d]: got %h expected %h", i, obs, e);
      end
      if (i == 5) begin
        checks++;
        if (err_order !== 1'b1 || err_dur !== 1'b0 || phase !== 2'b10 || err_sticky !== 3'b010) begin
          errors++;
          $display("FAIL order_pulse: got order=%b dur=%b phase=%b sticky=%b expected 1 0 10 010",
                   err_order, err_dur, phase, err_sticky);
        end
      end
    end
  endtask

  task automatic test_code();
    logic [3:0] seq [11];
    logic [19:0] e;
    seq = '{YC, R, R, R, R, R, G, G, 4'b0110, G, Y};
    for (int i = 0; i < 11; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL code[%0d]: got %h expected %h", i, obs, e);
      end
      if (i == 8) begin
        checks++;
        if (err_code !== 1'b1 || phase !== 2'b01 || phase_len !== 4'd2) begin
          errors++;
          $display("FAIL code_pulse: got code=%b phase=%b len=%0d expected 1 01 2", err_code, phase, phase_len);
        end
      end
      if (i == 10) begin
        checks++;
        if (err_code !== 1'b0 || err_dur !== 1'b0) begin
          errors++;
          $display("FAIL code_no_dur: got code=%b dur=%b expected 0 0", err_code, err_dur);
        end
      end
    end
  endtask

  task automatic test_dark();
    logic [3:0] seq [13];
    logic [19:0] e;
    seq = '{Y, RC, R, R, R, R, G, G, D, D, D, G, Y};
    for (int i = 0; i < 13; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL dark[%0d]: got %h expected %h", i, obs, e);
      end
      if (i >= 8 && i <= 10) begin
        checks++;
        if (phase_len !== 4'd2 || phase !== 2'b01) begin
          errors++;
          $display("FAIL dark_hold[%0d]: got len=%0d phase=%b expected 2 01", i, phase_len, phase);
        end
      end
      if (i == 11) begin
        checks++;
        if (phase_len !== 4'd3) begin
          errors++;
          $display("FAIL dark_resume: got len=%0d expected 3", phase_len);
        end
      end
      if (i == 12) begin
        checks++;
        if (err_sticky !== 3'b000 || err_dur !== 1'b0) begin
          errors++;
          $display("FAIL dark_errors: got sticky=%b dur=%b expected 000 0", err_sticky, err_dur);
        end
      end
    end
  endtask

  task automatic test_clr_order();
    logic [3:0] seq [4];
    logic [19:0] e;
    seq = '{Y, 4'b0111, Y, GC};
    for (int i = 0; i < 4; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL clr_order[%0d]: got %h expected %h", i, obs, e);
      end
      if (i == 3) begin
        checks++;
        if (err_sticky !== 3'b010 || err_order !== 1'b1) begin
          errors++;
          $display("FAIL clr_order_sticky: got sticky=%b order=%b expected 010 1", err_sticky, err_order);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [3];
    logic [19:0] e;
    seq = '{4'b0101, 4'b0011, 4'b0110};
    for (int i = 0; i < 3; i++) begin
      drive(seq[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h expected %h", i, obs, e);
      end
      checks++;
      if (err_code !== 1'b1) begin
        errors++;
        $display("FAIL b2b_code[%0d]: got %b expected 1", i, err_code);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] pre [3];
    logic [3:0] post [3];
    logic [19:0] e;
    pre  = '{Y, R, R};
    post = '{G, G, Y};
    for (int i = 0; i < 3; i++) begin
      drive(pre[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_pre[%0d]: got %h expected %h", i, obs, e);
      end
    end
    #3;
    areset_n = 1'b0;
    #1;
    checks++;
    if (obs !== RST_VEC) begin
      errors++;
      $display("FAIL areset_immediate: got %h expected %h", obs, RST_VEC);
    end
    model_reset();
    @(posedge clk); #1;
    areset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(post[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL areset_post[%0d]: got %h expected %h", i, obs, e);
      end
    end
    checks++;
    if (err_dur !== 1'b0 || err_order !== 1'b0) begin
      errors++;
      $display("FAIL areset_first_phase: got dur=%b order=%b expected 0 0", err_dur, err_order);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dur();
    test_order();
    test_code();
    test_dark();
    test_clr_order();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
